os_rx_sched: RTL and testbench

Controller wrapped around the receive ordered-set decoder.
- Owns the decoder's configuration (generation, detected lane count) and gates the LMC valid into it.
- Runs a flush window after every reconfiguration.
- Buffers decoded 2048-bit ordered sets in a 2-entry FIFO with a valid/ready handshake toward the LTSSM.
- Sits between the lane management/LMC block, the decoder and the LTSSM.

---
 rtl/os_rx_sched.sv | 162 ++++++++++++++++
 tb/tb_os_rx_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_rx_sched.sv
// Receive ordered-set scheduler: owns decoder config, flushes after reconfig,
// buffers decoded words in a 2-entry FIFO. Optional macro OS_LANE_MASK_EN zeroes unused lanes.
//
// state  | meaning
// IDLE   | after reset, decoder fed nothing, decoded words ignored
// FLUSH  | decoder valid held low for FLUSH_CYCLES after a config change
// RUN    | lmcValid forwarded to decoder, decoded words buffered
module os_rx_sched #(
    parameter int FLUSH_CYCLES = 4,
    parameter int OS_WIDTH     = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfgReq,
    input  logic [2:0]          cfgGen,
    input  logic [4:0]          cfgLanes,
    output logic                cfgAck,
    output logic                cfgErr,
    input  logic                lmcValid,
    output logic                decValidIn,
    output logic [2:0]          decGen,
    output logic [4:0]          decLanes,
    input  logic                decValid,
    input  logic [OS_WIDTH-1:0] decOs,
    output logic                osValid,
    input  logic                osReady,
    output logic [OS_WIDTH-1:0] osData,
    output logic [7:0]          dropCount,
    output logic                busy
);

    localparam int LANES_MAX = OS_WIDTH / 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          flush_cnt, flush_cnt_nxt;
    logic                lanes_legal;
    logic                cfg_legal;
    logic                cfg_bad;

    logic [OS_WIDTH-1:0] fifo_mem [2];
    logic [1:0]          occ;
    logic                rd_ptr;
    logic                wr_ptr;
    logic                push;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [OS_WIDTH-1:0] push_word;

    always_comb begin
        lanes_legal = 1'b0;
        case (cfgLanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_legal = 1'b1;
            default:                       lanes_legal = 1'b0;
        endcase
    end

    assign cfg_legal = cfgReq && (cfgGen >= 3'd1) && (cfgGen <= 3'd5) && lanes_legal;
    assign cfg_bad   = cfgReq && !cfg_legal;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        busy          = 1'b0;
        decValidIn    = 1'b0;
        case (state)
            ST_IDLE: begin
            end
            ST_FLUSH: begin
                busy          = 1'b1;
                flush_cnt_nxt = flush_cnt - 4'd1;
                // terminal count: the cycle holding 1 is the last flush cycle
                if (flush_cnt <= 4'd1) begin
                    flush_cnt_nxt = 4'd0;
                    state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                decValidIn = lmcValid;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (cfg_legal) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = 4'(FLUSH_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            flush_cnt <= 4'd0;
            cfgAck    <= 1'b0;
            cfgErr    <= 1'b0;
            decGen    <= 3'd1;
            decLanes  <= 5'd1;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            cfgAck    <= cfg_legal;
            cfgErr    <= cfg_bad;
            if (cfg_legal) begin
                decGen   <= cfgGen;
                decLanes <= cfgLanes;
            end
        end
    end

    always_comb begin
        push_word = decOs;
`ifdef OS_LANE_MASK_EN
        for (int k = 0; k < LANES_MAX; k++) begin
            if (k >= int'(decLanes)) begin
                push_word[128*k +: 128] = '0;
            end
        end
`endif
    end

    assign osValid = (occ != 2'd0);
    assign osData  = fifo_mem[rd_ptr];
    // with 2 slots the write slot is the read slot offset by occupancy
    assign wr_ptr  = rd_ptr ^ occ[0];
    assign push    = decValid && (state == ST_RUN) && !cfg_legal;
    assign pop     = osValid && osReady;
    assign push_ok = push && ((occ != 2'd2) || pop);
    assign drop    = push && (occ == 2'd2) && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ       <= 2'd0;
            rd_ptr    <= 1'b0;
            dropCount <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (drop && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'd1;
            end
            if (cfg_legal) begin
                occ    <= 2'd0;
                rd_ptr <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                if (push_ok) begin
                    fifo_mem[wr_ptr] <= push_word;
                end
                occ <= occ + {1'b0, push_ok} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_os_rx_sched.sv
// Self-checking bench for os_rx_sched: queue scoreboard of expected FIFO words
// plus small models of the flush timer and drop counter.
module tb_os_rx_sched;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfgReq;
    logic [2:0]    cfgGen;
    logic [4:0]    cfgLanes;
    logic          cfgAck;
    logic          cfgErr;
    logic          lmcValid;
    logic          decValidIn;
    logic [2:0]    decGen;
    logic [4:0]    decLanes;
    logic          decValid;
    logic [2047:0] decOs;
    logic          osValid;
    logic          osReady;
    logic [2047:0] osData;
    logic [7:0]    dropCount;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [2047:0] q[$];
    int            exp_drop;
    int            exp_st;
    int            exp_cnt;
    int            exp_lanes;

    os_rx_sched #(.FLUSH_CYCLES(4), .OS_WIDTH(2048)) dut (
        .clk(clk), .reset(reset),
        .cfgReq(cfgReq), .cfgGen(cfgGen), .cfgLanes(cfgLanes),
        .cfgAck(cfgAck), .cfgErr(cfgErr),
        .lmcValid(lmcValid), .decValidIn(decValidIn),
        .decGen(decGen), .decLanes(decLanes),
        .decValid(decValid), .decOs(decOs),
        .osValid(osValid), .osReady(osReady), .osData(osData),
        .dropCount(dropCount), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2047:0] mask_word(logic [2047:0] w, int lanes);
        logic [2047:0] r;
        r = w;
`ifdef OS_LANE_MASK_EN
        for (int k = 0; k < 16; k++) begin
            if (k >= lanes) r[128*k +: 128] = '0;
        end
`endif
        return r;
    endfunction

    function automatic logic [2047:0] make_word(logic [31:0] seed);
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) r[32*i +: 32] = seed ^ (i * 32'h9E37_79B9);
        return r;
    endfunction

    // advance the reference model by the inputs now applied, then cross one edge
    task automatic step();
        bit pop;
        bit legal;
        legal = cfgReq && (cfgGen >= 3'd1) && (cfgGen <= 3'd5) &&
                (cfgLanes inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16});
        pop = (q.size() != 0) && osReady;
        if (!reset) begin
            q.delete();
            exp_drop = 0; exp_st = 0; exp_cnt = 0; exp_lanes = 1;
        end else if (legal) begin
            q.delete();
            exp_st = 1; exp_cnt = 4; exp_lanes = int'(cfgLanes);
        end else begin
            if (pop) q.delete(0);
            if (decValid && exp_st == 2) begin
                if (q.size() < 2) q.push_back(mask_word(decOs, exp_lanes));
                else if (exp_drop < 255) exp_drop++;
            end
            if (exp_st == 1) begin
                exp_cnt--;
                if (exp_cnt == 0) exp_st = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; lmcValid = 1'b1;
        step();
        step();
        total++; if (osValid !== 1'b0) begin bad++; $display("FAIL reset_osValid got=%0b exp=0", osValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (decGen !== 3'd1 || decLanes !== 5'd1) begin bad++; $display("FAIL reset_cfg got gen=%0d lanes=%0d exp gen=1 lanes=1", decGen, decLanes); end
        total++; if (dropCount !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", dropCount); end
        total++; if (cfgAck !== 1'b0 || cfgErr !== 1'b0) begin bad++; $display("FAIL reset_pulses got ack=%0b err=%0b exp 0 0", cfgAck, cfgErr); end
        total++; if (decValidIn !== 1'b0 || osData !== '0) begin bad++; $display("FAIL reset_idle got dvi=%0b data_lo=%0h exp 0 0", decValidIn, osData[63:0]); end
        reset = 1'b1;
        decValid = 1'b1; decOs = make_word(32'h1111_0000);
        step();
        decValid = 1'b0;
        total++; if (osValid !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%0b exp=0", osValid); end
    endtask

    task automatic do_config(logic [2:0] g, logic [4:0] l);
        cfgReq = 1'b1; cfgGen = g; cfgLanes = l;
        step();
        cfgReq = 1'b0;
    endtask

    task automatic wait_flush(string nm);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy !== 1'b1 || decValidIn !== 1'b0) begin
                bad++; $display("FAIL %s_flush%0d got busy=%0b dvi=%0b exp 1 0", nm, i, busy, decValidIn);
            end
            step();
        end
        total++;
        if (busy !== 1'b0 || exp_st != 2) begin bad++; $display("FAIL %s_to_run got busy=%0b exp 0", nm, busy); end
    endtask

    task automatic test_config();
        lmcValid = 1'b1;
        do_config(3'd1, 5'd2);
        total++; if (cfgAck !== 1'b1 || cfgErr !== 1'b0) begin bad++; $display("FAIL cfg_ack got ack=%0b err=%0b exp 1 0", cfgAck, cfgErr); end
        total++; if (decLanes !== 5'd2 || decGen !== 3'd1) begin bad++; $display("FAIL cfg_regs got gen=%0d lanes=%0d exp 1 2", decGen, decLanes); end
        decValid = 1'b1; decOs = make_word(32'h2222_0000);
        wait_flush("cfg");
        decValid = 1'b0;
        total++; if (osValid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%0b exp=0", osValid); end
        total++; if (decValidIn !== 1'b1) begin bad++; $display("FAIL run_dvi_hi got=%0b exp=1", decValidIn); end
        lmcValid = 1'b0; #1;
        total++; if (decValidIn !== 1'b0) begin bad++; $display("FAIL run_dvi_lo got=%0b exp=0", decValidIn); end
        total++; if (cfgAck !== 1'b0) begin bad++; $display("FAIL cfg_ack_single got=%0b exp=0", cfgAck); end
    endtask

    task automatic test_illegal();
        lmcValid = 1'b1;
        do_config(3'd2, 5'd3);
        total++; if (cfgErr !== 1'b1 || cfgAck !== 1'b0) begin bad++; $display("FAIL illegal_err got err=%0b ack=%0b exp 1 0", cfgErr, cfgAck); end
        total++; if (decLanes !== 5'd2 || decGen !== 3'd1 || busy !== 1'b0 || decValidIn !== 1'b1) begin
            bad++; $display("FAIL illegal_hold got lanes=%0d gen=%0d busy=%0b dvi=%0b exp 2 1 0 1", decLanes, decGen, busy, decValidIn);
        end
        do_config(3'd6, 5'd4);
        total++; if (cfgErr !== 1'b1 || decLanes !== 5'd2) begin bad++; $display("FAIL illegal_gen got err=%0b lanes=%0d exp 1 2", cfgErr, decLanes); end
        step();
        total++; if (cfgErr !== 1'b0) begin bad++; $display("FAIL illegal_single got=%0b exp=0", cfgErr); end
    endtask

    task automatic drain(string nm);
        osReady = 1'b1;
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            total++;
            if (osValid !== 1'b1 || osData !== q[0]) begin
                bad++; $display("FAIL %s_pop%0d got v=%0b lo=%0h exp v=1 lo=%0h", nm, i, osValid, osData[63:0], q[0][63:0]);
            end
            step();
        end
        osReady = 1'b0;
        total++; if (osValid !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL %s_empty got v=%0b exp=0", nm, osValid); end
    endtask

    task automatic test_fifo_full();
        logic [2047:0] a;
        a = make_word(32'hAAAA_0001);
        osReady = 1'b0;
        decValid = 1'b1;
        decOs = a;                         step();
        decOs = make_word(32'hBBBB_0002);  step();
        decOs = make_word(32'hCCCC_0003);  step();
        decValid = 1'b0;
        step();
        total++; if (osValid !== 1'b1 || osData !== mask_word(a, 2)) begin bad++; $display("FAIL full_head got v=%0b lo=%0h exp v=1 lo=%0h", osValid, osData[63:0], a[63:0]); end
        total++; if (dropCount !== 8'd1 || exp_drop != 1) begin bad++; $display("FAIL full_drop got=%0d exp=1", dropCount); end
        drain("full");
    endtask

    task automatic test_back_to_back();
        logic [2047:0] d;
        d = make_word(32'hDDDD_0004);
        osReady = 1'b0; decValid = 1'b1;
        decOs = make_word(32'hAAAA_0011); step();
        decOs = make_word(32'hBBBB_0012); step();
        decOs = d; osReady = 1'b1;        step();
        decValid = 1'b0; osReady = 1'b0;
        total++; if (q.size() != 2 || osData !== q[0]) begin bad++; $display("FAIL b2b_head got lo=%0h exp lo=%0h", osData[63:0], q[0][63:0]); end
        total++; if (dropCount !== 8'd1) begin bad++; $display("FAIL b2b_drop got=%0d exp=1", dropCount); end
        step();
        total++; if (osValid !== 1'b1 || osData !== q[0]) begin bad++; $display("FAIL b2b_stable got lo=%0h exp lo=%0h", osData[63:0], q[0][63:0]); end
        drain("b2b");
        total++; if (q.size() != 0) begin bad++; $display("FAIL b2b_d_seen got=%0d exp=0", q.size()); end
    endtask

    task automatic test_saturate();
        osReady = 1'b0; decValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            decOs = make_word(32'h5000_0000 + i);
            step();
        end
        decValid = 1'b0;
        total++; if (dropCount !== 8'd255 || exp_drop != 255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", dropCount); end
        total++; if (osValid !== 1'b1 || osData !== q[0]) begin bad++; $display("FAIL sat_head got lo=%0h exp lo=%0h", osData[63:0], q[0][63:0]); end
        do_config(3'd3, 5'd16);
        total++; if (osValid !== 1'b0 || dropCount !== 8'd255 || cfgAck !== 1'b1) begin
            bad++; $display("FAIL sat_reconfig got v=%0b drop=%0d ack=%0b exp 0 255 1", osValid, dropCount, cfgAck);
        end
        wait_flush("sat");
    endtask

    task automatic test_reset_mid_flush();
        osReady = 1'b0;
        decValid = 1'b1; decOs = make_word(32'h7777_0001); step();
        total++; if (osValid !== 1'b1 || osData !== q[0]) begin bad++; $display("FAIL one_entry got v=%0b exp=1", osValid); end
        decOs = make_word(32'h7777_0002);
        cfgReq = 1'b1; cfgGen = 3'd5; cfgLanes = 5'd8;
        step();
        cfgReq = 1'b0; decValid = 1'b0;
        total++; if (osValid !== 1'b0 || dropCount !== 8'd255 || busy !== 1'b1) begin
            bad++; $display("FAIL cfg_push_collide got v=%0b drop=%0d busy=%0b exp 0 255 1", osValid, dropCount, busy);
        end
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++; if (busy !== 1'b0 || osValid !== 1'b0 || dropCount !== 8'd0) begin
            bad++; $display("FAIL rst_flush got busy=%0b v=%0b drop=%0d exp 0 0 0", busy, osValid, dropCount);
        end
        total++; if (decLanes !== 5'd1 || decGen !== 3'd1 || cfgAck !== 1'b0) begin
            bad++; $display("FAIL rst_flush_cfg got lanes=%0d gen=%0d exp 1 1", decLanes, decGen);
        end
        lmcValid = 1'b1; #1;
        total++; if (decValidIn !== 1'b0) begin bad++; $display("FAIL rst_idle_dvi got=%0b exp=0", decValidIn); end
    endtask

    task automatic test_lane_mask();
        logic [2047:0] ones;
        logic [2047:0] want;
        ones = '1;
        do_config(3'd4, 5'd2);
        wait_flush("mask");
        decValid = 1'b1; decOs = ones; step();
        decValid = 1'b0;
`ifdef OS_LANE_MASK_EN
        want = '0;
        want[255:0] = '1;
`else
        want = ones;
`endif
        total++; if (osValid !== 1'b1 || osData !== want || q[0] !== want) begin
            bad++; $display("FAIL lane_mask got hi=%0h lo=%0h exp hi=%0h lo=%0h", osData[2047:1984], osData[63:0], want[2047:1984], want[63:0]);
        end
        drain("mask");
    endtask

    initial begin
        reset = 1'b0; cfgReq = 1'b0; cfgGen = 3'd0; cfgLanes = 5'd0;
        lmcValid = 1'b0; decValid = 1'b0; decOs = '0; osReady = 1'b0;
        q.delete(); exp_drop = 0; exp_st = 0; exp_cnt = 0; exp_lanes = 1;
        #1;
        test_reset();
        test_config();
        test_illegal();
        test_fifo_full();
        test_back_to_back();
        test_saturate();
        test_reset_mid_flush();
        test_lane_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
